jk_seq_driver: RTL and testbench

Sequence driver for a bank of JK flip-flops built from our `jkff` cell. It holds a small programmable table of target states and, on `start`, walks the table. For each entry it computes the J/K excitation that moves the bank from its current state to the target. It then checks the bank's fed-back `q` against the target and flags mismatches. It is the controlling side of the JK interface: it produces `j`/`k` from desired next states, where the flip-flop produces next state from `j`/`k`.

---
 rtl/jk_seq_driver_if.sv | 32 +++
 rtl/jk_seq_driver.sv | 131 +++++++++++++
 tb/tb_jk_seq_driver.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/jk_seq_driver_if.sv
// Bundle between a JK sequence driver and whoever programs it / owns the JK bank.
// Latency: none, this is wiring only.
// Backpressure: none; the busy flag tells the programmer when writes and starts are ignored.
interface jk_seq_driver_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 3
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic [AW:0]      len;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;
    logic [AW-1:0]    err_step;

    // Programming / bank side: drives table writes, start and the bank feedback.
    modport master (
        output wr_en, wr_addr, wr_data, start, len, q_fb,
        input  j, k, busy, done, err, err_step
    );

    // Sequence driver side.
    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, q_fb,
        output j, k, busy, done, err, err_step
    );
endinterface

// File: rtl/jk_seq_driver.sv
// Walks a table of target states, drives J/K excitation to a JK bank and checks the fed-back q.
// Latency: 3 cycles per step (DRIVE, APPLY, CHECK); done pulses the cycle after the last CHECK.
// Backpressure: writes and starts are ignored while busy; a mismatch is flagged but never stalls.
module jk_seq_driver #(
    parameter int WIDTH       = 4,
    parameter int AW          = 3,
    parameter bit TOGGLE_MODE = 1'b0
) (
    input logic             clk,
    input logic             reset,
    jk_seq_driver_if.slave  bus
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, DRIVE, APPLY, CHECK} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      eff_len_q, eff_len_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [AW-1:0]    err_step_q, err_step_d;

    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;

    // Target table: only writable while idle, deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state_q == IDLE)) begin
            tbl_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign tgt = tbl_q[idx_q];

    // Excitation from current bank state to target: set/reset per bit, or toggle both on change.
    always_comb begin
        exc_j = '0;
        exc_k = '0;
        if (TOGGLE_MODE) begin
            exc_j = tgt ^ bus.q_fb;
            exc_k = tgt ^ bus.q_fb;
        end else begin
            exc_j = tgt & ~bus.q_fb;
            exc_k = ~tgt & bus.q_fb;
        end
    end

    // Next-state and output logic; j/k default to 0 so they are only nonzero while in APPLY.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        eff_len_d  = eff_len_q;
        j_d        = '0;
        k_d        = '0;
        done_d     = 1'b0;
        err_d      = err_q;
        err_step_d = err_step_q;
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    state_d    = DRIVE;
                    idx_d      = '0;
                    err_d      = 1'b0;
                    err_step_d = '0;
                    eff_len_d  = (bus.len > DEPTH_V) ? DEPTH_V : bus.len;
                end
            end
            DRIVE: begin
                j_d     = exc_j;
                k_d     = exc_k;
                state_d = APPLY;
            end
            APPLY: begin
                state_d = CHECK;
            end
            CHECK: begin
                // Only the first mismatching step is recorded.
                if ((bus.q_fb != tgt) && !err_q) begin
                    err_d      = 1'b1;
                    err_step_d = idx_q;
                end
                if ({1'b0, idx_q} == (eff_len_q - 1'b1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            eff_len_q  <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_step_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            eff_len_q  <= eff_len_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_step_q <= err_step_d;
        end
    end

    assign bus.j        = j_q;
    assign bus.k        = k_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_step = err_step_q;
endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: two instances (set/reset and toggle excitation) driving modelled JK banks.
// Expected outputs come from a step-level model of the table walk, checked every cycle.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_jk_seq_driver;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic [3:0] len;
    logic [3:0] stuck;
    logic       bank_ld;
    logic [3:0] bank_val;
    logic [3:0] bank0, bank1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] tbl_m [8];
    logic [3:0] q_m;

    always #5 clk = ~clk;

    jk_seq_driver_if #(.WIDTH(4), .AW(3)) if0 ();
    jk_seq_driver_if #(.WIDTH(4), .AW(3)) if1 ();

    assign if0.wr_en = wr_en;   assign if1.wr_en = wr_en;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
    assign if0.start = start;   assign if1.start = start;
    assign if0.len = len;       assign if1.len = len;
    assign if0.q_fb = bank0 & ~stuck;
    assign if1.q_fb = bank1 & ~stuck;

    jk_seq_driver #(.WIDTH(4), .AW(3), .TOGGLE_MODE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    jk_seq_driver #(.WIDTH(4), .AW(3), .TOGGLE_MODE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j, input logic [3:0] k);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) begin
            case ({j[b], k[b]})
                2'b00:   r[b] = q[b];
                2'b01:   r[b] = 1'b0;
                2'b10:   r[b] = 1'b1;
                default: r[b] = ~q[b];
            endcase
        end
        return r;
    endfunction

    // JK banks: behavioural flip-flops, with a loadable start state.
    always @(posedge clk) begin
        if (bank_ld) begin
            bank0 <= bank_val;
            bank1 <= bank_val;
        end else begin
            bank0 <= jk_next(if0.q_fb, if0.j, if0.k);
            bank1 <= jk_next(if1.q_fb, if1.j, if1.k);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic eb, input logic ed,
                           input logic [3:0] j0e, input logic [3:0] k0e, input logic [3:0] jk1e,
                           input logic ee, input logic [2:0] ese);
        chk({nm, " busy0"}, {31'd0, if0.busy}, {31'd0, eb});
        chk({nm, " busy1"}, {31'd0, if1.busy}, {31'd0, eb});
        chk({nm, " done0"}, {31'd0, if0.done}, {31'd0, ed});
        chk({nm, " done1"}, {31'd0, if1.done}, {31'd0, ed});
        chk({nm, " j0"}, {28'd0, if0.j}, {28'd0, j0e});
        chk({nm, " k0"}, {28'd0, if0.k}, {28'd0, k0e});
        chk({nm, " j1"}, {28'd0, if1.j}, {28'd0, jk1e});
        chk({nm, " k1"}, {28'd0, if1.k}, {28'd0, jk1e});
        chk({nm, " err0"}, {31'd0, if0.err}, {31'd0, ee});
        chk({nm, " err1"}, {31'd0, if1.err}, {31'd0, ee});
        chk({nm, " err_step0"}, {29'd0, if0.err_step}, {29'd0, ese});
        chk({nm, " err_step1"}, {29'd0, if1.err_step}, {29'd0, ese});
    endtask

    task automatic wr(input int a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a[2:0]; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        tbl_m[a] = d;
    endtask

    task automatic load_bank(input logic [3:0] v);
        bank_ld = 1'b1; bank_val = v;
        @(negedge clk);
        bank_ld = 1'b0;
        q_m = v & ~stuck;
    endtask

    // One full run from start through the done cycle. Leaves time at the done cycle so a
    // following call issues its start while done is high.
    task automatic run_seq(input string nm, input int ln, input bit do_wr, input int wa,
                           input logic [3:0] wd, input bit busy_wr);
        logic [3:0] ej0 [8];
        logic [3:0] ek0 [8];
        logic [3:0] ej1 [8];
        logic [3:0] t, qm;
        logic [3:0] ej, ek, et;
        logic       ee;
        int eff, first_bad, step;
        if (do_wr) tbl_m[wa] = wd;
        eff = (ln > 8) ? 8 : ln;
        qm = q_m;
        first_bad = -1;
        for (int n = 0; n < eff; n++) begin
            t = tbl_m[n];
            ej0[n] = t & ~qm;
            ek0[n] = ~t & qm;
            ej1[n] = t ^ qm;
            qm = t & ~stuck;
            if (qm != t && first_bad < 0) first_bad = n;
        end
        q_m = qm;
        start = 1'b1; len = ln[3:0];
        if (do_wr) begin wr_en = 1'b1; wr_addr = wa[2:0]; wr_data = wd; end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        for (int m = 0; m < 3 * eff; m++) begin
            step = m / 3;
            ej = '0; ek = '0; et = '0;
            if (m % 3 == 1) begin ej = ej0[step]; ek = ek0[step]; et = ej1[step]; end
            ee = (first_bad >= 0) && (m >= 3 * (first_bad + 1));
            chk_out($sformatf("%s c%0d", nm, m), 1'b1, 1'b0, ej, ek, et, ee,
                    ee ? first_bad[2:0] : 3'd0);
            // A write while busy must not reach the table (model table untouched).
            wr_en = busy_wr && (m == 1);
            wr_addr = 3'd0; wr_data = ~tbl_m[0];
            @(negedge clk);
            wr_en = 1'b0;
        end
        chk_out({nm, " done"}, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, first_bad >= 0,
                (first_bad >= 0) ? first_bad[2:0] : 3'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rv;
        int rl;
        reset = 1'b1; start = 1'b1; len = 4'd3; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        stuck = '0; bank_ld = 1'b1; bank_val = '0;

        // Reset held two cycles with start high: everything stays quiet.
        repeat (2) begin
            @(negedge clk);
            chk_out("reset", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0);
        end
        reset = 1'b0; start = 1'b0; bank_ld = 1'b0; q_m = '0;
        @(negedge clk);
        chk("post_reset busy0", {31'd0, if0.busy}, 32'd0);

        // Directed walk 1010 -> 0110 -> 0000 from a cleared bank.
        wr(0, 4'b1010); wr(1, 4'b0110); wr(2, 4'b0000);
        for (int a = 3; a < 8; a++) wr(a, 4'($urandom));
        load_bank(4'b0000);
        run_seq("basic", 3, 1'b0, 0, 4'd0, 1'b0);

        // Bit0 stuck low: first mismatch at step 0, run still completes.
        stuck = 4'b0001;
        wr(0, 4'b0001); wr(1, 4'b0011);
        load_bank(4'b0000);
        run_seq("stuck", 2, 1'b0, 0, 4'd0, 1'b0);
        stuck = 4'b0000;

        // len=0 start is ignored.
        start = 1'b1; len = 4'd0;
        @(negedge clk);
        chk("len0 busy0", {31'd0, if0.busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("len0 busy1", {31'd0, if1.busy}, 32'd0);

        // len=12 clamps to 8, write during busy ignored, back-to-back start in the done cycle.
        for (int a = 0; a < 8; a++) wr(a, 4'($urandom));
        load_bank(4'($urandom));
        run_seq("clamp", 12, 1'b0, 0, 4'd0, 1'b1);
        run_seq("b2b", 8, 1'b0, 0, 4'd0, 1'b0);
        // Write and start in the same cycle (also the done cycle): new entry 0 is used.
        rv = 4'($urandom);
        run_seq("wrstart", 2, 1'b1, 0, rv, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 8; a++) wr(a, 4'($urandom));
            stuck = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            load_bank(4'($urandom));
            rl = $urandom_range(1, 12);
            run_seq($sformatf("rand%0d", r), rl, 1'b0, 0, 4'd0, 1'b0);
        end
        stuck = 4'b0000;

        // Reset during APPLY of step 1.
        @(negedge clk);
        wr(0, 4'b1010); wr(1, 4'b0110); wr(2, 4'b0000);
        load_bank(4'b0000);
        start = 1'b1; len = 4'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort apply j0", {28'd0, if0.j}, 32'h4);
        chk("abort apply k0", {28'd0, if0.k}, 32'h8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_out("abort", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0);
        @(negedge clk);
        chk_out("abort+1", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 3'd0);
        load_bank(4'b0000);
        run_seq("after_abort", 1, 1'b0, 0, 4'd0, 1'b0);
        @(negedge clk);
        chk("idle after run busy0", {31'd0, if0.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
